fifo_stream_reader: RTL and testbench

// Read-side controller for the synchronous FIFO. On a start command it drains exactly `len` words from the FIFO.
// It absorbs the FIFO's 1-cycle read latency (fifo_rd_en -> fifo_valid/fifo_bus_out) with a 2-entry output buffer.

---
 rtl/fifo_stream_reader.sv | 110 +++++++++++
 tb/tb_fifo_stream_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side burst controller: drains `len` words from a FIFO with 1-cycle read latency
// into a 2-entry skid buffer and presents them on a valid/ready stream.
module fifo_stream_reader #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 protocol_err_o,
  output logic                 fifo_rd_en_o,
  input  logic                 fifo_empty_i,
  input  logic [BUS_WIDTH-1:0] fifo_bus_out_i,
  input  logic                 fifo_valid_i,
  output logic [BUS_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     rd_rem_q, rd_rem_d;
  logic [LEN_W-1:0]     out_rem_q, out_rem_d;
  logic                 inflight_q, inflight_d;
  logic                 perr_q, perr_d;
  logic [1:0]           occ_q, occ_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [BUS_WIDTH-1:0] data_q [2];

  logic       pop, capture;
  logic [2:0] slots;

  assign m_valid_o      = (occ_q != 2'd0);
  assign m_data_o       = data_q[rd_ptr_q];
  assign m_last_o       = m_valid_o & (out_rem_q == LEN_W'(1));
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign protocol_err_o = perr_q;

  assign pop     = m_valid_o & m_ready_i;
  assign capture = inflight_q & fifo_valid_i;
  // Buffer slots committed after this edge: held words plus the one in flight, minus a pop.
  assign slots   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_rd_en_o = (state_q == StRun) & ~fifo_empty_i & (rd_rem_q != '0) & (slots < 3'd2);

  always_comb begin
    state_d    = state_q;
    rd_rem_d   = rd_rem_q;
    out_rem_d  = out_rem_q;
    perr_d     = perr_q;
    inflight_d = fifo_rd_en_o;
    occ_d      = occ_q + {1'b0, capture} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q ^ capture;
    rd_ptr_d   = rd_ptr_q ^ pop;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          rd_rem_d  = len_i;
          out_rem_d = len_i;
          perr_d    = 1'b0;
          state_d   = (len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pop && m_last_o) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fifo_rd_en_o) rd_rem_d = rd_rem_q - LEN_W'(1);
    if (pop) out_rem_d = out_rem_q - LEN_W'(1);
    // A spurious qualifier wins over the clear on a coincident start.
    if (fifo_valid_i && !inflight_q) perr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_rem_q   <= '0;
      out_rem_q  <= '0;
      inflight_q <= 1'b0;
      perr_q     <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      rd_rem_q   <= rd_rem_d;
      out_rem_q  <= out_rem_d;
      inflight_q <= inflight_d;
      perr_q     <= perr_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (capture) data_q[wr_ptr_q] <= fifo_bus_out_i;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-backed FIFO model, expected stream taken from the
// words pushed into that model, random backpressure and push timing.
module tb_fifo_stream_reader;
  localparam int BW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, perr, rd_en, fifo_empty, fifo_valid;
  logic [BW-1:0] fifo_data = '0;
  logic [BW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic          fv_q = 1'b0;
  logic          inject = 1'b0;

  logic [BW-1:0] mem [256];
  int wr_idx = 0;
  int rd_idx = 0;
  int errors = 0;
  int checks = 0;

  fifo_stream_reader #(.BUS_WIDTH(BW), .LEN_W(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .len_i          (len),
    .busy_o         (busy),
    .done_o         (done),
    .protocol_err_o (perr),
    .fifo_rd_en_o   (rd_en),
    .fifo_empty_i   (fifo_empty),
    .fifo_bus_out_i (fifo_data),
    .fifo_valid_i   (fifo_valid),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_last_o       (m_last)
  );

  always #5 clk = ~clk;

  // FIFO model: data and qualifier appear one cycle after a read request.
  assign fifo_empty = (wr_idx == rd_idx);
  assign fifo_valid = fv_q | inject;
  always @(posedge clk) begin
    fv_q <= rd_en;
    if (rd_en) begin
      fifo_data <= mem[rd_idx % 256];
      rd_idx    <= rd_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] v);
    mem[wr_idx % 256] = v;
    wr_idx++;
  endtask

  // One burst of n words; pre words pushed before start, up to late words pushed during it.
  task automatic burst(input int n, input int pre, input int late, input int ready_pct,
                       input int push_pct, input int hold, input bit poke);
    int base, k, rd_cnt, cyc, pushed, left_before;
    bit last_prev, stall_prev, finished, acc;
    logic [BW-1:0] pdata;
    logic plast;
    k = 0; rd_cnt = 0; cyc = 0; pushed = 0;
    stall_prev = 0; finished = 0; pdata = '0; plast = 0;
    for (int i = 0; i < pre; i++) begin push(BW'($urandom)); pushed++; end
    @(negedge clk);
    left_before = wr_idx - rd_idx - pushed;
    base = rd_idx;
    start = 1'b1;
    len = LW'(n);
    @(negedge clk);
    len = LW'($urandom);
    last_prev = (n == 0);
    while (!finished) begin
      m_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (late > 0 && $urandom_range(99) < push_pct) begin
        push(BW'($urandom)); pushed++; late--;
      end
      start = (poke && cyc == 2);
      #1;
      if (fifo_empty) chk("no_rd_when_empty", rd_en, 0);
      if (ready_pct == 100 && hold == 0 && cyc < n && left_before + pre >= n)
        chk("full_rate_rd", rd_en, 1);
      if (rd_en) rd_cnt++;
      chk("busy", busy, 1);
      chk("done", done, last_prev);
      chk("last_qualified", m_last & ~m_valid, 0);
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pdata);
        chk("hold_last", m_last, plast);
      end
      acc = m_valid && m_ready;
      if (acc) begin
        chk("beat_in_range", k < n, 1);
        chk("data", m_data, mem[(base + k) % 256]);
        chk("last", m_last, k == n - 1);
        k++;
      end
      finished   = last_prev;
      last_prev  = acc && (k == n);
      stall_prev = m_valid && !m_ready;
      pdata      = m_data;
      plast      = m_last;
      if (hold > 0 && cyc == hold - 1) chk("bp_rd_cnt", rd_cnt, (n < 2) ? n : 2);
      cyc++;
      if (!finished && cyc > 500) begin
        chk("burst_timeout_beats", k, n + 1);
        finished = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", m_valid, 0);
    chk("rd_count", rd_cnt, n);
    chk("fifo_left", wr_idx - rd_idx, left_before + pushed - n);
  endtask

  initial begin
    int acc_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_perr", perr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight burst, then the same under initial backpressure.
    for (int i = 11; i <= 14; i++) push(BW'(i));
    burst(4, 0, 0, 100, 0, 0, 0);
    for (int i = 11; i <= 14; i++) push(BW'(i));
    burst(4, 0, 0, 100, 0, 6, 0);

    // Empty FIFO at start, words trickle in.
    burst(3, 0, 3, 100, 30, 0, 0);

    // Zero-length burst, and a start pulse while busy.
    burst(0, 0, 0, 100, 0, 0, 0);
    burst(3, 3, 0, 100, 0, 0, 1);

    for (int r = 0; r < 8; r++) begin
      int n, extra, pre;
      n = $urandom_range(1, 12);
      extra = $urandom_range(0, 3);
      pre = $urandom_range(0, n + extra);
      burst(n, pre, n + extra - pre, 60, 50, 0, 0);
    end

    // Reset in the middle of a burst, then a fresh burst.
    for (int i = 0; i < 5; i++) push(BW'($urandom));
    @(negedge clk);
    start = 1'b1;
    len = LW'(5);
    @(negedge clk);
    start = 1'b0;
    m_ready = 1'b1;
    acc_cnt = 0;
    for (int c = 0; c < 20 && acc_cnt < 2; c++) begin
      #1;
      if (m_valid && m_ready) acc_cnt++;
      if (acc_cnt < 2) @(negedge clk);
    end
    chk("mid_burst_beats", acc_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    burst(2, 2, 0, 100, 0, 0, 0);

    // Qualifier with no read in flight sets a sticky error; start clears it.
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1;
    chk("perr_set", perr, 1);
    chk("perr_idle", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("perr_sticky", perr, 1);
    burst(0, 0, 0, 100, 0, 0, 0);
    chk("perr_cleared", perr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
